// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Width of a counter that must reach w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mult_addsub.sv
// (WIDTH+1)-bit add/subtract of the accumulator high half and the multiplicand.
// Operands are zero- or sign-extended by signed_mode; en=0 passes hi through.
module mult_addsub
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] mcand,
   input  logic             signed_mode,
   input  logic             sub,
   input  logic             en,
   output logic [WIDTH:0]   S
);

   logic [WIDTH:0] w_hi_ext;
   logic [WIDTH:0] w_mc_ext;

   assign w_hi_ext = {signed_mode & hi[WIDTH-1], hi};
   assign w_mc_ext = {signed_mode & mcand[WIDTH-1], mcand};

   always_comb begin
      S = w_hi_ext;
      if (en) begin
         S = sub ? (w_hi_ext - w_mc_ext) : (w_hi_ext + w_mc_ext);
      end
   end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier, unsigned or two's complement per operation.
// WIDTH cycles after START capture; START at any edge restarts the operation.
module seq_mult_shift_add
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic                         CK,
   input  logic                         RST,
   input  logic                         START,
   input  logic                         SIGNED,
   input  logic [WIDTH-1:0]             A,
   input  logic [WIDTH-1:0]             B,
   output logic [2*WIDTH-1:0]           P,
   output logic                         READY,
   output logic                         DONE,
   output logic [cnt_width(WIDTH)-1:0]  CNT
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_p;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic                 r_mode;
   logic                 r_ready;
   logic                 r_done;

   logic                 w_last;
   logic                 w_sub;
   logic [WIDTH:0]       w_s;

   assign w_last = (r_cnt == LAST);
   // The multiplier sign bit carries negative weight in signed mode.
   assign w_sub  = r_mode & w_last;

   mult_addsub #(.WIDTH(WIDTH)) u_addsub (
      .hi          (r_p[2*WIDTH-1:WIDTH]),
      .mcand       (r_mcand),
      .signed_mode (r_mode),
      .sub         (w_sub),
      .en          (r_p[0]),
      .S           (w_s)
   );

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_cnt   <= '0;
         r_mcand <= '0;
         r_mode  <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else if (START) begin
         r_mcand <= A;
         r_mode  <= SIGNED;
         r_p     <= {{WIDTH{1'b0}}, B};
         r_cnt   <= '0;
         r_state <= S_RUN;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_p   <= {w_s, r_p[WIDTH-1:1]};
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= S_DONE;
                  r_ready <= 1'b1;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign P     = r_p;
   assign READY = r_ready;
   assign DONE  = r_done;
   assign CNT   = r_cnt;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for the shift-add multiplier at WIDTH=4 and a WIDTH=8 sweep.
module tb_seq_mult_shift_add;

   logic       ck;
   logic       rst;
   logic       start4, sgn4;
   logic [3:0] a4, b4;
   logic [7:0] p4;
   logic       ready4, done4;
   logic [2:0] cnt4;

   logic        start8, sgn8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        ready8, done8;
   logic [3:0]  cnt8;

   int n_tests = 0;
   int n_fail  = 0;

   seq_mult_shift_add #(.WIDTH(4)) u_dut4 (
      .CK(ck), .RST(rst), .START(start4), .SIGNED(sgn4), .A(a4), .B(b4),
      .P(p4), .READY(ready4), .DONE(done4), .CNT(cnt4)
   );

   seq_mult_shift_add #(.WIDTH(8)) u_dut8 (
      .CK(ck), .RST(rst), .START(start8), .SIGNED(sgn8), .A(a8), .B(b8),
      .P(p8), .READY(ready8), .DONE(done8), .CNT(cnt8)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge after the capture edge.
   task automatic start4_op(input logic [3:0] a, input logic [3:0] b, input logic s);
      start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
      @(negedge ck);
      start4 = 1'b0;
   endtask

   // Counts edges from capture until DONE is seen.
   task automatic wait_done4(output int n);
      n = 0;
      while (!done4 && n < 20) begin
         @(negedge ck);
         n++;
      end
      if (!done4) chk("done4_timeout", 32'(done4), 32'd1);
   endtask

   task automatic finish4(input string tag, input logic [7:0] exp);
      int n;
      chk({tag, "_ready_low"}, 32'(ready4), 32'd0);
      wait_done4(n);
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_p"}, 32'(p4), 32'(exp));
      chk({tag, "_ready"}, 32'(ready4), 32'd1);
      chk({tag, "_cnt"}, 32'(cnt4), 32'd4);
      @(negedge ck);
      chk({tag, "_done_fall"}, 32'(done4), 32'd0);
      chk({tag, "_p_hold"}, 32'(p4), 32'(exp));
   endtask

   initial begin
      int n;
      logic [7:0]  ra, rb;
      logic        rs;
      int          sa, sb, prod;
      logic [15:0] exp8;

      rst = 1'b1;
      start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      @(negedge ck);
      @(negedge ck);
      chk("rst_p", 32'(p4), 32'd0);
      chk("rst_ready", 32'(ready4), 32'd1);
      chk("rst_done", 32'(done4), 32'd0);
      chk("rst_cnt", 32'(cnt4), 32'd0);
      rst = 1'b0;
      @(negedge ck);

      start4_op(4'd7, 4'd5, 1'b0);
      finish4("u7x5", 8'h23);

      // Back-to-back restart on the DONE cycle.
      start4_op(4'd15, 4'd15, 1'b0);
      chk("u15x15_ready_low", 32'(ready4), 32'd0);
      wait_done4(n);
      chk("u15x15_latency", 32'(n), 32'd4);
      chk("u15x15_p", 32'(p4), 32'hE1);
      start4_op(4'd0, 4'd9, 1'b0);
      chk("b2b_done_fall", 32'(done4), 32'd0);
      chk("b2b_ready_low", 32'(ready4), 32'd0);
      wait_done4(n);
      chk("b2b_gap", 32'(n + 1), 32'd5);
      chk("b2b_p", 32'(p4), 32'h00);
      @(negedge ck);

      start4_op(4'h8, 4'h8, 1'b1);
      finish4("s_m8xm8", 8'h40);
      start4_op(4'hD, 4'h5, 1'b1);
      finish4("s_m3x5", 8'hF1);
      start4_op(4'h7, 4'hF, 1'b1);
      finish4("s_7xm1", 8'hF9);
      start4_op(4'hF, 4'hF, 1'b0);
      finish4("u15x15_again", 8'hE1);

      // Abort mid-run.
      start4_op(4'd3, 4'd3, 1'b0);
      @(negedge ck);
      @(negedge ck);
      chk("abort_cnt2", 32'(cnt4), 32'd2);
      start4_op(4'd2, 4'd6, 1'b0);
      chk("abort_cnt_restart", 32'(cnt4), 32'd0);
      finish4("abort_2x6", 8'h0C);

      // Asynchronous reset mid-run.
      start4_op(4'd9, 4'd9, 1'b0);
      @(negedge ck);
      chk("rstmid_cnt1", 32'(cnt4), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_p", 32'(p4), 32'd0);
      chk("rstmid_ready", 32'(ready4), 32'd1);
      chk("rstmid_done", 32'(done4), 32'd0);
      chk("rstmid_cnt", 32'(cnt4), 32'd0);
      @(negedge ck);
      rst = 1'b0;
      @(negedge ck);
      start4_op(4'd9, 4'd9, 1'b0);
      finish4("u9x9", 8'h51);

      // WIDTH=8: corners then random operands.
      for (int i = 0; i < 24; i++) begin
         case (i)
            0: begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            1: begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
            2: begin ra = 8'hFF; rb = 8'hFF; rs = 1'b1; end
            3: begin ra = 8'h7F; rb = 8'h80; rs = 1'b1; end
            default: begin
               ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            end
         endcase
         if (rs) begin
            sa = {{24{ra[7]}}, ra};
            sb = {{24{rb[7]}}, rb};
         end else begin
            sa = {24'd0, ra};
            sb = {24'd0, rb};
         end
         prod = sa * sb;
         exp8 = prod[15:0];
         start8 = 1'b1; a8 = ra; b8 = rb; sgn8 = rs;
         @(negedge ck);
         start8 = 1'b0;
         n = 0;
         while (!done8 && n < 30) begin
            @(negedge ck);
            n++;
         end
         chk($sformatf("w8_%0d_latency", i), 32'(n), 32'd8);
         chk($sformatf("w8_%0d_p", i), 32'(p8), 32'(exp8));
         @(negedge ck);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
